// File: rtl/tank_game_pkg.sv
// Shared types and helpers for the tank game blocks: wave FSM states,
// counter widths and the per-level enemy total.
package tank_game_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2
  } wave_state_t;

  localparam int MAX_LEVEL   = 10;
  localparam int ENEMY_CNT_W = 6;

  // base + 2*level in 7 bits, saturated to the 6-bit counter range.
  // Levels beyond MAX_LEVEL are treated as MAX_LEVEL.
  function automatic logic [ENEMY_CNT_W-1:0] level_total(input int unsigned base,
                                                         input logic [3:0] level);
    logic [3:0] lvl;
    logic [6:0] sum;
    lvl = (level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level;
    sum = 7'(base) + {2'b00, lvl, 1'b0};
    return (sum > 7'd63) ? 6'd63 : sum[5:0];
  endfunction

endpackage

// File: rtl/enemy_wave_ctrl_if.sv
// Signal bundle between the wave controller, the game FSM and the tank spawner.
// spawn_req_o is held high until a cycle with spawn_ack_i=1; that cycle completes the transfer.
interface enemy_wave_ctrl_if;
  import tank_game_pkg::*;

  logic                   reset_game_i;
  logic                   is_playing_i;
  logic [3:0]             level_i;
  logic                   enemy_killed_i;
  logic                   spawn_ack_i;
  logic                   spawn_req_o;
  logic [1:0]             spawn_slot_o;
  logic                   spawn_special_o;
  logic [3:0]             active_count_o;
  logic [ENEMY_CNT_W-1:0] enemy_left_o;

  modport master (
    input  reset_game_i, is_playing_i, level_i, enemy_killed_i, spawn_ack_i,
    output spawn_req_o, spawn_slot_o, spawn_special_o, active_count_o, enemy_left_o
  );

  modport slave (
    output reset_game_i, is_playing_i, level_i, enemy_killed_i, spawn_ack_i,
    input  spawn_req_o, spawn_slot_o, spawn_special_o, active_count_o, enemy_left_o
  );
endinterface

// File: rtl/enemy_wave_ctrl.sv
// Per-level enemy bookkeeping: paces spawn requests, rotates spawn points,
// tags special enemies and tracks pending/active counts for level completion.
module enemy_wave_ctrl
  import tank_game_pkg::*;
#(
  parameter int BASE_ENEMIES   = 4,
  parameter int MAX_ACTIVE     = 4,
  parameter int SPAWN_INTERVAL = 25000000,
  parameter int NUM_SLOTS      = 3,
  parameter int SPECIAL_EVERY  = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  enemy_wave_ctrl_if.master    bus,
  output wave_state_t          state_o
);

  localparam int TIMER_W = $clog2(SPAWN_INTERVAL);
  localparam int IDX_W   = (SPECIAL_EVERY > 1) ? $clog2(SPECIAL_EVERY) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SPAWN_INTERVAL - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(SPECIAL_EVERY - 1);
  localparam logic [1:0]         SLOT_LAST  = 2'(NUM_SLOTS - 1);
  localparam logic [3:0]         ACTIVE_MAX = 4'(MAX_ACTIVE);

  wave_state_t            state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [ENEMY_CNT_W-1:0] pending_q, pending_d;
  logic [ENEMY_CNT_W-1:0] left_q, left_d;
  logic [3:0]             active_q, active_d;
  logic [1:0]             slot_q, slot_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   req_q, req_d;
  logic                   special_q, special_d;

  logic                   ack_ok;
  logic                   kill_ok;
  logic [ENEMY_CNT_W-1:0] reload_total;

  assign reload_total = level_total(BASE_ENEMIES, bus.level_i);
  assign ack_ok  = (state_q == REQ) && bus.spawn_ack_i;
  assign kill_ok = bus.enemy_killed_i && (active_q != 4'd0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    left_d    = left_q;
    active_d  = active_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    req_d     = req_q;

    if (bus.reset_game_i) begin
      state_d   = HOLD;
      timer_d   = '0;
      pending_d = reload_total;
      left_d    = reload_total;
      active_d  = '0;
      slot_d    = '0;
      idx_d     = '0;
      req_d     = 1'b0;
    end else begin
      // A spawn moves one enemy from pending to active, so only kills touch left.
      pending_d = pending_q - {{(ENEMY_CNT_W-1){1'b0}}, ack_ok};
      active_d  = active_q + {3'b000, ack_ok} - {3'b000, kill_ok};
      left_d    = left_q - {{(ENEMY_CNT_W-1){1'b0}}, kill_ok};

      case (state_q)
        HOLD: begin
          if (bus.is_playing_i) state_d = WAIT;
        end
        WAIT: begin
          // Timer parks at terminal count until pending and field room allow a spawn.
          if (bus.is_playing_i) begin
            if (timer_q != TIMER_LAST) begin
              timer_d = timer_q + 1'b1;
            end else if ((pending_q != '0) && (active_q < ACTIVE_MAX)) begin
              state_d = REQ;
              timer_d = '0;
              req_d   = 1'b1;
            end
          end
        end
        REQ: begin
          if (ack_ok) begin
            state_d = WAIT;
            req_d   = 1'b0;
            slot_d  = (slot_q == SLOT_LAST) ? 2'd0 : slot_q + 2'd1;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
        end
        default: begin
          state_d = HOLD;
          req_d   = 1'b0;
        end
      endcase
    end

    special_d = (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= HOLD;
      timer_q   <= '0;
      pending_q <= level_total(BASE_ENEMIES, 4'd1);
      left_q    <= level_total(BASE_ENEMIES, 4'd1);
      active_q  <= '0;
      slot_q    <= '0;
      idx_q     <= '0;
      req_q     <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      left_q    <= left_d;
      active_q  <= active_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      special_q <= special_d;
    end
  end

  assign bus.spawn_req_o     = req_q;
  assign bus.spawn_slot_o    = slot_q;
  assign bus.spawn_special_o = special_q;
  assign bus.active_count_o  = active_q;
  assign bus.enemy_left_o    = left_q;
  assign state_o             = state_q;

endmodule
